// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline types: vertex sequencer state encoding, data width
// default, fixed-point component format and result-RAM capacity helper.
package gfx_pkg;

  localparam int VXF_DW       = 32;
  localparam int FX_FRAC_BITS = 16;
  localparam int FX_INT_BITS  = VXF_DW - FX_FRAC_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPD,
    S_UPD_WAIT,
    S_SETUP,
    S_FETCH,
    S_MUL,
    S_MUL_WAIT,
    S_WRITE
  } vxf_state_t;

  // Whole vertices that fit in a result RAM of 2**out_aw words.
  function automatic logic [31:0] vxf_capacity(input int out_aw, input int comp);
    return 32'((2 ** out_aw) / comp);
  endfunction

endpackage

// File: rtl/vxf_result_ram.sv
// Simple dual-port result RAM: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module vxf_result_ram
  import gfx_pkg::*;
#(
  parameter int DW = VXF_DW,
  parameter int AW = 7
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vertex_xform_seq.sv
// Vertex transform sequencer: mesh fetch -> matrix engine -> result RAM, plus matrix-update jobs.
// Optional VXF_CYCLE_CNT_EN adds a saturating busy-cycle counter output cycle_cnt.
module vertex_xform_seq
  import gfx_pkg::*;
#(
  parameter int DW     = VXF_DW,
  parameter int COMP   = 3,
  parameter int AW     = 16,
  parameter int OUT_AW = 7,
  parameter int RD_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 update_mvp,
  input  logic [AW-1:0]        mesh_base,
  input  logic [31:0]          count,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [AW-1:0]        mesh_addr,
  output logic                 mesh_rd,
  input  logic [DW-1:0]        mesh_data,
  output logic                 mul_start,
  output logic                 mul_upd,
  output logic [COMP*DW-1:0]   mul_in,
  input  logic                 mul_done,
  input  logic [COMP*DW-1:0]   mul_out,
  input  logic [OUT_AW-1:0]    result_addr,
  output logic [DW-1:0]        result_data
`ifdef VXF_CYCLE_CNT_EN
  ,
  output logic [31:0]          cycle_cnt
`endif
);

  localparam int IW = (COMP > 1) ? $clog2(COMP) : 1;
  localparam int CW = $clog2(COMP + 1);
  localparam logic [31:0] CAP = vxf_capacity(OUT_AW, COMP);

  vxf_state_t                 state_reg, state_next;
  logic [AW-1:0]              mesh_addr_reg, mesh_addr_next;
  logic [AW-1:0]              base_reg, base_next;
  logic [31:0]                count_reg, count_next;
  logic [31:0]                n_eff_reg, n_eff_next;
  logic [31:0]                vtx_reg, vtx_next;
  logic [OUT_AW-1:0]          wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]              fetch_cnt_reg, fetch_cnt_next;
  logic [IW-1:0]              comp_cnt_reg, comp_cnt_next;
  logic [COMP-1:0][DW-1:0]    mul_in_reg, mul_in_next;
  logic [COMP-1:0][DW-1:0]    res_reg, res_next;
  logic                       overflow_reg, overflow_next;
  logic                       done_reg, done_next;

  // Slot-index delay line: a read's slot pops out exactly when its data arrives.
  logic [RD_LAT-1:0]          pipe_vld_reg;
  logic [IW-1:0]              pipe_idx_reg [RD_LAT];
  logic                       cap_vld;
  logic [IW-1:0]              cap_idx;
  logic                       ram_we;

  assign cap_vld   = pipe_vld_reg[RD_LAT-1];
  assign cap_idx   = pipe_idx_reg[RD_LAT-1];
  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign overflow  = overflow_reg;
  assign mesh_addr = mesh_addr_reg;
  assign mesh_rd   = (state_reg == S_FETCH) && (fetch_cnt_reg < CW'(COMP));
  assign mul_start = (state_reg == S_MUL) || (state_reg == S_UPD);
  assign mul_upd   = (state_reg == S_UPD);
  assign mul_in    = mul_in_reg;
  // Gate with reset so the edge that aborts a job commits no write.
  assign ram_we    = (state_reg == S_WRITE) && !reset;

  always_comb begin
    state_next     = state_reg;
    mesh_addr_next = mesh_addr_reg;
    base_next      = base_reg;
    count_next     = count_reg;
    n_eff_next     = n_eff_reg;
    vtx_next       = vtx_reg;
    wr_ptr_next    = wr_ptr_reg;
    fetch_cnt_next = fetch_cnt_reg;
    comp_cnt_next  = comp_cnt_reg;
    mul_in_next    = mul_in_reg;
    res_next       = res_reg;
    overflow_next  = overflow_reg;
    done_next      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          overflow_next = 1'b0;
          base_next     = mesh_base;
          count_next    = count;
          if (update_mvp) begin
            mul_in_next = '0;
            state_next  = S_UPD;
          end else begin
            state_next  = S_SETUP;
          end
        end
      end
      S_UPD: begin
        mul_in_next = '0;
        state_next  = S_UPD_WAIT;
      end
      S_UPD_WAIT: begin
        if (mul_done) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_SETUP: begin
        n_eff_next     = (count_reg > CAP) ? CAP : count_reg;
        overflow_next  = (count_reg > CAP);
        vtx_next       = '0;
        wr_ptr_next    = '0;
        fetch_cnt_next = '0;
        mesh_addr_next = base_reg;
        if (n_eff_next == 32'd0) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mesh_rd) begin
          mesh_addr_next = mesh_addr_reg + AW'(1);
          fetch_cnt_next = fetch_cnt_reg + CW'(1);
        end
        if (cap_vld) begin
          mul_in_next[cap_idx] = mesh_data;
          if (cap_idx == IW'(COMP - 1)) state_next = S_MUL;
        end
      end
      S_MUL: state_next = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (mul_done) begin
          res_next      = mul_out;
          comp_cnt_next = '0;
          state_next    = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_ptr_next   = wr_ptr_reg + OUT_AW'(1);
        comp_cnt_next = comp_cnt_reg + IW'(1);
        if (comp_cnt_reg == IW'(COMP - 1)) begin
          comp_cnt_next = '0;
          vtx_next      = vtx_reg + 32'd1;
          if (vtx_reg + 32'd1 == n_eff_reg) begin
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            fetch_cnt_next = '0;
            state_next     = S_FETCH;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      mesh_addr_reg <= '0;
      base_reg      <= '0;
      count_reg     <= '0;
      n_eff_reg     <= '0;
      vtx_reg       <= '0;
      wr_ptr_reg    <= '0;
      fetch_cnt_reg <= '0;
      comp_cnt_reg  <= '0;
      mul_in_reg    <= '0;
      res_reg       <= '0;
      overflow_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mesh_addr_reg <= mesh_addr_next;
      base_reg      <= base_next;
      count_reg     <= count_next;
      n_eff_reg     <= n_eff_next;
      vtx_reg       <= vtx_next;
      wr_ptr_reg    <= wr_ptr_next;
      fetch_cnt_reg <= fetch_cnt_next;
      comp_cnt_reg  <= comp_cnt_next;
      mul_in_reg    <= mul_in_next;
      res_reg       <= res_next;
      overflow_reg  <= overflow_next;
      done_reg      <= done_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld_reg <= '0;
    end else begin
      pipe_vld_reg[0] <= mesh_rd;
      for (int i = 1; i < RD_LAT; i++) pipe_vld_reg[i] <= pipe_vld_reg[i-1];
    end
    pipe_idx_reg[0] <= IW'(fetch_cnt_reg);
    for (int i = 1; i < RD_LAT; i++) pipe_idx_reg[i] <= pipe_idx_reg[i-1];
  end

  vxf_result_ram #(
    .DW (DW),
    .AW (OUT_AW)
  ) u_result_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wr_ptr_reg),
    .wdata (res_reg[comp_cnt_reg]),
    .raddr (result_addr),
    .rdata (result_data)
  );

`ifdef VXF_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_reg <= '0;
    end else if (state_reg == S_IDLE && start) begin
      cycle_cnt_reg <= '0;
    end else if (state_reg != S_IDLE && cycle_cnt_reg != '1) begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
`endif

endmodule
